// File: rtl/sha3_digest_squeeze.sv
// Digest squeeze stage: latches a captured 5x5 Keccak state and streams the first OUT_LANES lanes.
// Optional build macro SHA3_SQUEEZE_BYTESWAP_EN byte-reverses each emitted lane for hex-digest sinks.
//
// state | meaning
// IDLE  | waiting for igood; iready high, ovalid low
// EMIT  | streaming lane_buf[idx]; ovalid high until the olast handshake
module sha3_digest_squeeze #(
  parameter int OUT_LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [319:0] isa,
  input  logic [319:0] isb,
  input  logic [319:0] isc,
  input  logic [319:0] isd,
  input  logic [319:0] ise,
  input  logic         igood,
  output logic         iready,
  output logic [63:0]  odata,
  output logic         ovalid,
  input  logic         oready,
  output logic         olast,
  output logic         overrun
);

  localparam int IW = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(OUT_LANES - 1);

  generate
    if (OUT_LANES < 1 || OUT_LANES > 25) begin : g_bad_out_lanes
      $error("sha3_digest_squeeze: OUT_LANES must be in 1..25");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           load;
  logic [63:0]    lane_buf [OUT_LANES];
  logic [63:0]    lane_sel;
  logic [4:0][319:0] rows;

  // rows[r] holds row r; lane k sits at row k/5, element k%5
  assign rows = {ise, isd, isc, isb, isa};

  // Lanes at or beyond OUT_LANES are deliberately left unread.
  logic unused_rows;
  assign unused_rows = ^rows;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (igood) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (oready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath buffer needs no reset: it is only observed in EMIT, after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < OUT_LANES; k++) begin
        lane_buf[k] <= rows[k / 5][64 * (k % 5) +: 64];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (igood && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end
  end

  function automatic logic [63:0] byte_rev(input logic [63:0] v);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) begin
      r[8 * b +: 8] = v[56 - 8 * b +: 8];
    end
    return r;
  endfunction

`ifdef SHA3_SQUEEZE_BYTESWAP_EN
  assign lane_sel = byte_rev(lane_buf[idx_q]);
`else
  assign lane_sel = lane_buf[idx_q];
`endif

  assign iready = (state_q == IDLE);
  assign ovalid = (state_q == EMIT);
  assign olast  = ovalid && (idx_q == LAST_IDX);
  assign odata  = ovalid ? lane_sel : 64'd0;

endmodule

// File: tb/tb_sha3_digest_squeeze.sv
// Directed bench for sha3_digest_squeeze: OUT_LANES=4 main instance plus 8- and 1-lane variants.
module tb_sha3_digest_squeeze;

  logic clk = 1'b0;
  logic rst;
  logic [4:0][319:0] tb_rows;
  logic [319:0] isa, isb, isc, isd, ise;
  logic igood, oready, igood_v, oready_v;

  logic iready, ovalid, olast, overrun;
  logic [63:0] odata;
  logic iready8, ovalid8, olast8, overrun8;
  logic [63:0] odata8;
  logic iready1, ovalid1, olast1, overrun1;
  logic [63:0] odata1;

  int n_tests = 0;
  int n_fail  = 0;

  assign isa = tb_rows[0];
  assign isb = tb_rows[1];
  assign isc = tb_rows[2];
  assign isd = tb_rows[3];
  assign ise = tb_rows[4];

  always #5 clk = ~clk;

  sha3_digest_squeeze #(.OUT_LANES(4)) dut (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood), .iready(iready), .odata(odata), .ovalid(ovalid), .oready(oready),
    .olast(olast), .overrun(overrun));

  sha3_digest_squeeze #(.OUT_LANES(8)) dut8 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood_v), .iready(iready8), .odata(odata8), .ovalid(ovalid8), .oready(oready_v),
    .olast(olast8), .overrun(overrun8));

  sha3_digest_squeeze #(.OUT_LANES(1)) dut1 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood_v), .iready(iready1), .odata(odata1), .ovalid(ovalid1), .oready(oready_v),
    .olast(olast1), .overrun(overrun1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] swap64(input logic [63:0] v);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8 * b +: 8] = v[56 - 8 * b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_lane(input logic [63:0] v);
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
    return swap64(v);
`else
    return v;
`endif
  endfunction

  task automatic load_state(input logic [63:0] base);
    for (int k = 0; k < 25; k++) tb_rows[k / 5][64 * (k % 5) +: 64] = base + 64'(k);
  endtask

  task automatic pulse();
    igood = 1'b1;
    step();
    igood = 1'b0;
  endtask

  task automatic drain4(input string tag, input logic [63:0] base);
    oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, 64'(ovalid), 64'd1);
      chk({tag, "_data"}, odata, exp_lane(base + 64'(k)));
      chk({tag, "_last"}, 64'(olast), 64'(k == 3));
      step();
    end
  endtask

  localparam logic [63:0] B2 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] B3 = 64'h2222_0000_0000_0000;
  localparam logic [63:0] BA = 64'h3333_0000_0000_0000;
  localparam logic [63:0] BB = 64'h4444_0000_0000_0000;
  localparam logic [63:0] BC = 64'h5555_0000_0000_0000;
  localparam logic [63:0] BD = 64'h6666_0000_0000_0000;

  initial begin
    logic [6:0] pat;
    int idx_m;

    rst = 1'b1; igood = 1'b0; oready = 1'b0; igood_v = 1'b0; oready_v = 1'b1;
    load_state(64'd0);
    step(); step(); step();
    chk("rst_iready", 64'(iready), 64'd1);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_olast", 64'(olast), 64'd0);
    chk("rst_odata", odata, 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    step();

    // scenario 2: full-rate drain
    oready = 1'b1;
    load_state(B2);
    chk("s2_iready_pre", 64'(iready), 64'd1);
    pulse();
    drain4("s2", B2);
    chk("s2_iready_after", 64'(iready), 64'd1);
    chk("s2_ovalid_after", 64'(ovalid), 64'd0);

    // scenario 3: oready pattern 1,0,0,1,0,1,1 (bit c used in cycle c)
    pat = 7'b1101001;
    load_state(B3);
    pulse();
    idx_m = 0;
    for (int c = 0; c < 7; c++) begin
      oready = pat[c];
      chk("s3_valid", 64'(ovalid), 64'd1);
      chk("s3_data", odata, exp_lane(B3 + 64'(idx_m)));
      chk("s3_last", 64'(olast), 64'(idx_m == 3));
      step();
      if (pat[c]) idx_m++;
    end
    chk("s3_ovalid_after", 64'(ovalid), 64'd0);
    chk("s3_overrun_clear", 64'(overrun), 64'd0);

    // scenario 4: strobes while busy
    oready = 1'b0;
    load_state(BA);
    pulse();
    load_state(BB);
    pulse();
    chk("s4_overrun_set", 64'(overrun), 64'd1);
    chk("s4_hold_data", odata, exp_lane(BA));
    oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s4_data", odata, exp_lane(BA + 64'(k)));
      if (k == 3) igood = 1'b1;
      step();
      igood = 1'b0;
    end
    chk("s4_late_ovalid", 64'(ovalid), 64'd0);
    chk("s4_late_iready", 64'(iready), 64'd1);
    load_state(BC);
    pulse();
    drain4("s4c", BC);
    chk("s4_overrun_sticky", 64'(overrun), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s4_overrun_rst", 64'(overrun), 64'd0);

    // scenario 5: reset mid-emit
    oready = 1'b1;
    load_state(BD);
    pulse();
    chk("s5_lane0", odata, exp_lane(BD));
    step();
    chk("s5_lane1", odata, exp_lane(BD + 64'd1));
    step();
    rst = 1'b1;
    oready = 1'b0;
    step();
    rst = 1'b0;
    chk("s5_ovalid", 64'(ovalid), 64'd0);
    chk("s5_iready", 64'(iready), 64'd1);
    chk("s5_odata", odata, 64'd0);
    load_state(64'd0);
    pulse();
    drain4("s5n", 64'd0);

    // scenario 6: byte order of lane 0
    oready = 1'b0;
    load_state(64'h0706050403020100);
    pulse();
`ifdef SHA3_SQUEEZE_BYTESWAP_EN
    chk("s6_swap", odata, 64'h0001020304050607);
`else
    chk("s6_raw", odata, 64'h0706050403020100);
`endif
    oready = 1'b1;
    step(); step(); step(); step();
    chk("s6_done", 64'(iready), 64'd1);

    // scenario 2 on the 8-lane and 1-lane variants
    load_state(B2);
    igood_v = 1'b1;
    step();
    igood_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("v8_valid", 64'(ovalid8), 64'd1);
      chk("v8_data", odata8, exp_lane(B2 + 64'(k)));
      chk("v8_last", 64'(olast8), 64'(k == 7));
      if (k == 0) begin
        chk("v1_data", odata1, exp_lane(B2));
        chk("v1_last", 64'(olast1), 64'd1);
        chk("v1_valid", 64'(ovalid1), 64'd1);
      end
      if (k == 1) begin
        chk("v1_idle_valid", 64'(ovalid1), 64'd0);
        chk("v1_idle_iready", 64'(iready1), 64'd1);
      end
      step();
    end
    chk("v8_iready", 64'(iready8), 64'd1);
    chk("v8_overrun", 64'(overrun8), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
